seg7_scan_capture: RTL

- Receiving end of the multiplexed 7-segment display interface that the stopwatch top level drives.
- Samples the scanned seg/an lines, waits for each digit dwell to settle, and decodes the segment pattern back to a digit value.
- Assembles the four digits into one frame.
- Used as an on-board loopback monitor and as the self-checking observer in stopwatch benches, so tests compare numbers instead of segment patterns.

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_pattern_decode.sv | 32 +++
 rtl/seg7_scan_capture.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment display path.
// Segment patterns are active-low and written seg[6:0] = {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic [3:0] DIGIT_ERR   = 4'hE;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low segment pattern back to its digit value.
// Unknown patterns decode to DIGIT_ERR, an all-off pattern to DIGIT_BLANK.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       valid,
    output logic       blank
);

    always_comb begin
        value = DIGIT_ERR;
        case (seg)
            SEG_0:     value = 4'd0;
            SEG_1:     value = 4'd1;
            SEG_2:     value = 4'd2;
            SEG_3:     value = 4'd3;
            SEG_4:     value = 4'd4;
            SEG_5:     value = 4'd5;
            SEG_6:     value = 4'd6;
            SEG_7:     value = 4'd7;
            SEG_8:     value = 4'd8;
            SEG_9:     value = 4'd9;
            SEG_BLANK: value = DIGIT_BLANK;
            default:   value = DIGIT_ERR;
        endcase
        valid = (value < 4'd10);
        blank = (value == DIGIT_BLANK);
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Observer for a scanned 7-segment display: synchronizes seg/an, captures each
// settled digit dwell, and assembles four digits into a frame with a staleness timeout.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int ERR_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg,
    input  logic [3:0]       an,
    output logic [15:0]      digits,
    output logic             frame_valid,
    output logic             stale,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int ST_W = $clog2(SETTLE_CYCLES);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_ARM  = ST_W'(SETTLE_CYCLES - 2);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    // Reset asserts immediately but releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 2'b00;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    logic [6:0]                 seg_meta_q, seg_s_q, seg_prev_q;
    logic [3:0]                 an_meta_q, an_s_q, an_prev_q;
    logic [ST_W-1:0]            settle_q, settle_d;
    logic [TO_W-1:0]            to_cnt_q, to_cnt_d;
    logic [NUM_DIGITS-1:0]      seen_q, seen_d, seen_next;
    logic [NUM_DIGITS-1:0][3:0] shadow_q, shadow_d;
    logic [15:0]                digits_q, digits_d;
    logic                       fv_q, fv_d;
    logic                       stale_q, stale_d;
    logic [ERR_W-1:0]           err_q, err_d;

    logic [3:0] dec_value;
    logic       dec_valid, dec_blank;
    logic [2:0] zero_cnt;
    logic [1:0] idx;
    logic       an_valid, same, capture, frame_done, timed_out;

    seg7_pattern_decode u_decode (
        .seg   (seg_s_q),
        .value (dec_value),
        .valid (dec_valid),
        .blank (dec_blank)
    );

    always_comb begin
        zero_cnt = 3'd0;
        idx      = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s_q[i]) begin
                zero_cnt = zero_cnt + 3'd1;
                idx      = 2'(i);
            end
        end
        an_valid = (zero_cnt == 3'd1);
        same     = (an_s_q == an_prev_q) && (seg_s_q == seg_prev_q);

        // The counter parks at ST_LAST so a long dwell captures only once.
        settle_d = '0;
        capture  = 1'b0;
        if (an_valid && same) begin
            settle_d = (settle_q == ST_LAST) ? settle_q : settle_q + 1'b1;
            capture  = (settle_q == ST_ARM);
        end

        err_d = err_q;
        if (capture && !dec_valid && !dec_blank && (err_q != '1))
            err_d = err_q + 1'b1;

        shadow_d  = shadow_q;
        seen_next = seen_q;
        if (capture) begin
            shadow_d[idx]  = dec_value;
            seen_next[idx] = 1'b1;
        end

        to_cnt_d = capture ? '0 : ((to_cnt_q == TO_LAST) ? to_cnt_q : to_cnt_q + 1'b1);
        timed_out  = !capture && (to_cnt_q == TO_LAST);
        frame_done = (seen_next == '1);

        digits_d = digits_q;
        fv_d     = 1'b0;
        stale_d  = stale_q;
        seen_d   = seen_next;
        if (frame_done) begin
            digits_d = shadow_d;
            fv_d     = 1'b1;
            stale_d  = 1'b0;
            seen_d   = '0;
        end else if (timed_out) begin
            stale_d = 1'b1;
            seen_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            seg_meta_q <= '1;
            seg_s_q    <= '1;
            seg_prev_q <= '1;
            an_meta_q  <= '1;
            an_s_q     <= '1;
            an_prev_q  <= '1;
            settle_q   <= '0;
            to_cnt_q   <= '0;
            seen_q     <= '0;
            shadow_q   <= '0;
            digits_q   <= 16'h0000;
            fv_q       <= 1'b0;
            stale_q    <= 1'b1;
            err_q      <= '0;
        end else begin
            seg_meta_q <= seg;
            seg_s_q    <= seg_meta_q;
            seg_prev_q <= seg_s_q;
            an_meta_q  <= an;
            an_s_q     <= an_meta_q;
            an_prev_q  <= an_s_q;
            settle_q   <= settle_d;
            to_cnt_q   <= to_cnt_d;
            seen_q     <= seen_d;
            shadow_q   <= shadow_d;
            digits_q   <= digits_d;
            fv_q       <= fv_d;
            stale_q    <= stale_d;
            err_q      <= err_d;
        end
    end

    assign digits      = digits_q;
    assign frame_valid = fv_q;
    assign stale       = stale_q;
    assign err_cnt     = err_q;

endmodule
